// File: rtl/kitchen_suppression_actuator_ctrl.sv
// Kitchen suppression actuator controller.
// Sequences the sprinkler valve through an open-confirmation handshake with
// timeout, a minimum hold time after the request drops, and a latched fault.
// Separately keeps the exhaust fan running for a fixed run-on period after
// the last ventilation demand. Every output is registered.
module kitchen_suppression_actuator_ctrl #(
  parameter int HOLD_CYCLES = 4096,
  parameter int ACK_TIMEOUT = 256,
  parameter int VENT_HOLD   = 8192,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sprinkler_req,
  input  logic       vent_req,
  input  logic       valve_open_ack,
  input  logic       fault_clear,
  output logic       valve_cmd,
  output logic       fan_cmd,
  output logic       sprinkler_active,
  output logic       fault,
  output logic [2:0] sp_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    OPENING = 3'd1,
    OPEN    = 3'd2,
    HOLD    = 3'd3,
    FAULT   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] VENT_LOAD = CNT_W'(VENT_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] vtmr_q;
  logic             demand;

  // Saturating increment shared by the OPENING timeout and the HOLD timer.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // Any pending or active sprinkler activity also keeps the fan running.
  assign demand = vent_req | sprinkler_req | (state_q != IDLE);

  assign sp_state = state_q;

  // Next-state and counter logic for the sprinkler valve sequence.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sprinkler_req) begin
          state_d = OPENING;
          cnt_d   = '0;
        end
      end
      OPENING: begin
        // A dropped request is ignored: the valve must confirm first.
        if (valve_open_ack)          state_d = OPEN;
        else if (cnt_q == ACK_LAST)  state_d = FAULT;
        else                         cnt_d   = cnt_inc;
      end
      OPEN: begin
        if (!valve_open_ack) begin
          state_d = FAULT;
        end else if (!sprinkler_req) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        // Losing the limit switch outranks a renewed request.
        if (!valve_open_ack)          state_d = FAULT;
        else if (sprinkler_req)       state_d = OPEN;
        else if (cnt_q == HOLD_LAST)  state_d = IDLE;
        else                          cnt_d   = cnt_inc;
      end
      FAULT: begin
        if (fault_clear && !sprinkler_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      vtmr_q           <= '0;
      valve_cmd        <= 1'b0;
      fan_cmd          <= 1'b0;
      sprinkler_active <= 1'b0;
      fault            <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      // Fail-safe: the valve stays commanded open in every non-idle state.
      valve_cmd        <= (state_d != IDLE);
      sprinkler_active <= (state_d == OPEN) || (state_d == HOLD);
      fault            <= (state_d == FAULT);
      if (demand) begin
        vtmr_q  <= VENT_LOAD;
        fan_cmd <= 1'b1;
      end else if (vtmr_q != '0) begin
        vtmr_q  <= vtmr_q - CNT_W'(1);
        fan_cmd <= 1'b1;
      end else begin
        fan_cmd <= 1'b0;
      end
    end
  end

endmodule
